complete: RTL and testbench

COMPLETE -- requirements
Module: complete

---
 rtl/complete_pkg.sv | 33 +++
 rtl/complete_rob_retire.sv | 145 ++++++++++++++
 rtl/complete.sv | 120 ++++++++++++
 tb/tb_complete.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complete_pkg.sv
// Shared types and constants for the complete stage and its reorder buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a; optional dual retirement is selected by COMPLETE_DUAL_RETIRE_EN.
package complete_pkg;

    localparam int         ROB_DEPTH    = 16;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;

    // One reorder-buffer row; instr_type=1 marks a store, which frees no register.
    typedef struct packed {
        logic        v;
        logic        instr_type;
        logic [5:0]  phy_reg;
        logic [31:0] result;
        logic [5:0]  old_phy;
        logic        comp;
    } rob_row;

    // Fresh row for a newly issued instruction: valid, not yet completed.
    function automatic rob_row new_row(input logic [6:0] opcode,
                                       input logic [5:0] p_reg,
                                       input logic [5:0] o_reg);
        rob_row r;
        r.v          = 1'b1;
        r.instr_type = (opcode == STORE_OPCODE);
        r.phy_reg    = p_reg;
        r.result     = '0;
        r.old_phy    = o_reg;
        r.comp       = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/complete_rob_retire.sv
// 16-entry circular reorder buffer: allocation at tail, completion by index, in-order retirement at head.
// Latency: retirement pulses appear one cycle after the edge that sees an entry completed.
// Backpressure: none; an allocation that would overflow is dropped whole. COMPLETE_DUAL_RETIRE_EN allows two retirements per cycle.
module rob_retire
    import complete_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        update_i,
    input  logic [6:0]  opcode_1_i,
    input  logic [5:0]  p_reg_1_i,
    input  logic [5:0]  o_reg_1_i,
    input  logic [6:0]  opcode_2_i,
    input  logic [5:0]  p_reg_2_i,
    input  logic [5:0]  o_reg_2_i,
    input  logic        res_vld_1_i,
    input  logic [3:0]  res_idx_1_i,
    input  logic [31:0] res_dat_1_i,
    input  logic        res_vld_2_i,
    input  logic [3:0]  res_idx_2_i,
    input  logic [31:0] res_dat_2_i,
    input  logic        res_vld_3_i,
    input  logic [3:0]  res_idx_3_i,
    input  logic [31:0] res_dat_3_i,
    output logic        retire_flag_1_o,
    output logic [5:0]  fp_ind_1_o,
    output logic        retire_flag_2_o,
    output logic [5:0]  fp_ind_2_o,
    output logic [4:0]  count_o,
    output logic        retired_any_o
);

    rob_row      rob_q [ROB_DEPTH];
    rob_row      rob_d [ROB_DEPTH];
    logic [3:0]  head_q, head_d;
    logic [3:0]  tail_q, tail_d;
    logic [4:0]  count_q, count_d;
    logic        ret_seen_q, ret_seen_d;
    logic        rf1_q, rf1_d, rf2_q, rf2_d;
    logic [5:0]  fp1_q, fp1_d, fp2_q, fp2_d;
    logic [1:0]  n_ret, n_alloc, alloc_n;
    logic        alloc_ok;
    logic [3:0]  wr_idx;
`ifdef COMPLETE_DUAL_RETIRE_EN
    logic [3:0]  head_nxt;
    assign head_nxt = head_q + 4'd1;
`endif

    // Next state: retire from head (using last edge's comp bits), then allocate, then record completions.
    always_comb begin
        rob_d = rob_q;
        n_ret = 2'd0;
        rf1_d = 1'b0;
        fp1_d = 6'd0;
        rf2_d = 1'b0;
        fp2_d = 6'd0;

        if (rob_q[head_q].v && rob_q[head_q].comp) begin
            rob_d[head_q].v    = 1'b0;
            rob_d[head_q].comp = 1'b0;
            rf1_d = ~rob_q[head_q].instr_type;
            fp1_d = rob_q[head_q].instr_type ? 6'd0 : rob_q[head_q].old_phy;
            n_ret = 2'd1;
`ifdef COMPLETE_DUAL_RETIRE_EN
            if (rob_q[head_nxt].v && rob_q[head_nxt].comp) begin
                rob_d[head_nxt].v    = 1'b0;
                rob_d[head_nxt].comp = 1'b0;
                rf2_d = ~rob_q[head_nxt].instr_type;
                fp2_d = rob_q[head_nxt].instr_type ? 6'd0 : rob_q[head_nxt].old_phy;
                n_ret = 2'd2;
            end
`endif
        end
        head_d = head_q + {2'b00, n_ret};

        // Overflow check uses the occupancy before this edge's retirements.
        n_alloc  = {1'b0, opcode_1_i != 7'd0} + {1'b0, opcode_2_i != 7'd0};
        alloc_ok = update_i && (({1'b0, count_q} + {4'd0, n_alloc}) <= 6'(ROB_DEPTH));
        wr_idx   = tail_q;
        if (alloc_ok) begin
            if (opcode_1_i != 7'd0) begin
                rob_d[wr_idx] = new_row(opcode_1_i, p_reg_1_i, o_reg_1_i);
                wr_idx = wr_idx + 4'd1;
            end
            if (opcode_2_i != 7'd0) begin
                rob_d[wr_idx] = new_row(opcode_2_i, p_reg_2_i, o_reg_2_i);
                wr_idx = wr_idx + 4'd1;
            end
        end
        tail_d  = wr_idx;
        alloc_n = alloc_ok ? n_alloc : 2'd0;

        // Applied in K order so the highest-numbered unit wins a shared index.
        if (res_vld_1_i) begin
            rob_d[res_idx_1_i].result = res_dat_1_i;
            rob_d[res_idx_1_i].comp   = 1'b1;
        end
        if (res_vld_2_i) begin
            rob_d[res_idx_2_i].result = res_dat_2_i;
            rob_d[res_idx_2_i].comp   = 1'b1;
        end
        if (res_vld_3_i) begin
            rob_d[res_idx_3_i].result = res_dat_3_i;
            rob_d[res_idx_3_i].comp   = 1'b1;
        end

        count_d    = count_q + {3'd0, alloc_n} - {3'd0, n_ret};
        ret_seen_d = ret_seen_q | (n_ret != 2'd0);
    end

    // ROB state and registered retirement outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ret_seen_q <= 1'b0;
            rf1_q      <= 1'b0;
            fp1_q      <= '0;
            rf2_q      <= 1'b0;
            fp2_q      <= '0;
        end else begin
            rob_q      <= rob_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ret_seen_q <= ret_seen_d;
            rf1_q      <= rf1_d;
            fp1_q      <= fp1_d;
            rf2_q      <= rf2_d;
            fp2_q      <= fp2_d;
        end
    end

    assign retire_flag_1_o = rf1_q;
    assign fp_ind_1_o      = fp1_q;
    assign retire_flag_2_o = rf2_q;
    assign fp_ind_2_o      = fp2_q;
    assign count_o         = count_q;
    assign retired_any_o   = ret_seen_q;

endmodule

// File: rtl/complete.sv
// Complete stage: result broadcast/PRF write registers, enable pipeline register, and the ROB.
// Latency: one cycle from result sampling to forward outputs; retirement one cycle after completion is seen.
// Backpressure: none; overflowing allocations are dropped. COMPLETE_DUAL_RETIRE_EN enables two retirements per cycle.
module complete
    import complete_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_flag_ci,
    input  logic [31:0] result_c1,
    input  logic [5:0]  result_dest_c1,
    input  logic        result_valid_c1,
    input  logic [3:0]  result_ROB_c1,
    input  logic [1:0]  result_FU_c1,
    input  logic [31:0] result_c2,
    input  logic [5:0]  result_dest_c2,
    input  logic        result_valid_c2,
    input  logic [3:0]  result_ROB_c2,
    input  logic [1:0]  result_FU_c2,
    input  logic [31:0] result_c3,
    input  logic [5:0]  result_dest_c3,
    input  logic        result_valid_c3,
    input  logic [3:0]  result_ROB_c3,
    input  logic [1:0]  result_FU_c3,
    output logic        en_flag_co,
    input  logic        update_rob,
    input  logic [5:0]  rob_p_reg_1,
    input  logic [6:0]  rob_opcode_1,
    input  logic [5:0]  o_rob_p_reg_1,
    input  logic [5:0]  rob_p_reg_2,
    input  logic [6:0]  rob_opcode_2,
    input  logic [5:0]  o_rob_p_reg_2,
    output logic        forward_flag_1,
    output logic [5:0]  dest_R_1,
    output logic [31:0] forwarded_data_1,
    output logic        forward_flag_2,
    output logic [5:0]  dest_R_2,
    output logic [31:0] forwarded_data_2,
    output logic        forward_flag_3,
    output logic [5:0]  dest_R_3,
    output logic [31:0] forwarded_data_3,
    output logic        retire_flag_1,
    output logic [5:0]  fp_ind_1,
    output logic        retire_flag_2,
    output logic [5:0]  fp_ind_2,
    input  logic [5:0]  pd_1_ci,
    output logic        pr_flag
);

    logic [4:0] rob_count;
    logic       retired_any;
    logic       unused_inputs;

    // FU tags and the reserved pd_1_ci port carry no function here.
    assign unused_inputs = ^{result_FU_c1, result_FU_c2, result_FU_c3, pd_1_ci};

    // Enable pipeline register and broadcast registers; dest/data hold while the flag is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_flag_co       <= 1'b0;
            forward_flag_1   <= 1'b0;
            dest_R_1         <= '0;
            forwarded_data_1 <= '0;
            forward_flag_2   <= 1'b0;
            dest_R_2         <= '0;
            forwarded_data_2 <= '0;
            forward_flag_3   <= 1'b0;
            dest_R_3         <= '0;
            forwarded_data_3 <= '0;
        end else begin
            en_flag_co     <= en_flag_ci;
            forward_flag_1 <= result_valid_c1;
            forward_flag_2 <= result_valid_c2;
            forward_flag_3 <= result_valid_c3;
            if (result_valid_c1) begin
                dest_R_1         <= result_dest_c1;
                forwarded_data_1 <= result_c1;
            end
            if (result_valid_c2) begin
                dest_R_2         <= result_dest_c2;
                forwarded_data_2 <= result_c2;
            end
            if (result_valid_c3) begin
                dest_R_3         <= result_dest_c3;
                forwarded_data_3 <= result_c3;
            end
        end
    end

    rob_retire u_rob (
        .clk             (clk),
        .rst             (rst),
        .update_i        (update_rob),
        .opcode_1_i      (rob_opcode_1),
        .p_reg_1_i       (rob_p_reg_1),
        .o_reg_1_i       (o_rob_p_reg_1),
        .opcode_2_i      (rob_opcode_2),
        .p_reg_2_i       (rob_p_reg_2),
        .o_reg_2_i       (o_rob_p_reg_2),
        .res_vld_1_i     (result_valid_c1),
        .res_idx_1_i     (result_ROB_c1),
        .res_dat_1_i     (result_c1),
        .res_vld_2_i     (result_valid_c2),
        .res_idx_2_i     (result_ROB_c2),
        .res_dat_2_i     (result_c2),
        .res_vld_3_i     (result_valid_c3),
        .res_idx_3_i     (result_ROB_c3),
        .res_dat_3_i     (result_c3),
        .retire_flag_1_o (retire_flag_1),
        .fp_ind_1_o      (fp_ind_1),
        .retire_flag_2_o (retire_flag_2),
        .fp_ind_2_o      (fp_ind_2),
        .count_o         (rob_count),
        .retired_any_o   (retired_any)
    );

    // Drained: nothing in flight, upstream idle, and something has actually retired.
    assign pr_flag = (rob_count == 5'd0) && !en_flag_ci && retired_any;

endmodule

// File: tb/tb_complete.sv
module tb_complete;

`ifdef COMPLETE_DUAL_RETIRE_EN
    localparam int RET_W = 2;
`else
    localparam int RET_W = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en_ci, update_rob;
    logic [5:0]  pd;
    logic [31:0] res_dat [3];
    logic [5:0]  res_dst [3];
    logic        res_vld [3];
    logic [3:0]  res_rob [3];
    logic [1:0]  res_fu  [3];
    logic [5:0]  p_reg [2];
    logic [5:0]  o_reg [2];
    logic [6:0]  opc   [2];
    logic        en_co, pr;
    logic        ff [3];
    logic [5:0]  dr [3];
    logic [31:0] fd [3];
    logic        rf [2];
    logic [5:0]  fp [2];

    int checks = 0;
    int fails  = 0;

    complete dut (
        .clk(clk), .rst(rst), .en_flag_ci(en_ci),
        .result_c1(res_dat[0]), .result_dest_c1(res_dst[0]), .result_valid_c1(res_vld[0]),
        .result_ROB_c1(res_rob[0]), .result_FU_c1(res_fu[0]),
        .result_c2(res_dat[1]), .result_dest_c2(res_dst[1]), .result_valid_c2(res_vld[1]),
        .result_ROB_c2(res_rob[1]), .result_FU_c2(res_fu[1]),
        .result_c3(res_dat[2]), .result_dest_c3(res_dst[2]), .result_valid_c3(res_vld[2]),
        .result_ROB_c3(res_rob[2]), .result_FU_c3(res_fu[2]),
        .en_flag_co(en_co), .update_rob(update_rob),
        .rob_p_reg_1(p_reg[0]), .rob_opcode_1(opc[0]), .o_rob_p_reg_1(o_reg[0]),
        .rob_p_reg_2(p_reg[1]), .rob_opcode_2(opc[1]), .o_rob_p_reg_2(o_reg[1]),
        .forward_flag_1(ff[0]), .dest_R_1(dr[0]), .forwarded_data_1(fd[0]),
        .forward_flag_2(ff[1]), .dest_R_2(dr[1]), .forwarded_data_2(fd[1]),
        .forward_flag_3(ff[2]), .dest_R_3(dr[2]), .forwarded_data_3(fd[2]),
        .retire_flag_1(rf[0]), .fp_ind_1(fp[0]),
        .retire_flag_2(rf[1]), .fp_ind_2(fp[1]),
        .pd_1_ci(pd), .pr_flag(pr)
    );

    // Reference model: program-order queue of ROB indices plus per-index attributes.
    int          q [$];
    bit          m_store [16];
    logic [5:0]  m_old   [16];
    bit          m_comp  [16];
    int          m_tail;
    bit          m_seen;
    bit          exp_ff [3];
    logic [5:0]  exp_dr [3];
    logic [31:0] exp_fd [3];
    bit          exp_rf [2];
    logic [5:0]  exp_fp [2];
    bit          exp_en;

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_seen = 0;
        exp_en = 0;
        for (int i = 0; i < 16; i++) begin
            m_comp[i] = 0; m_store[i] = 0; m_old[i] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            exp_ff[k] = 0; exp_dr[k] = '0; exp_fd[k] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            exp_rf[j] = 0; exp_fp[j] = '0;
        end
    endtask

    task automatic clear_inputs();
        update_rob = 0;
        pd = '0;
        for (int k = 0; k < 3; k++) begin
            res_vld[k] = 0; res_dat[k] = '0; res_dst[k] = '0; res_rob[k] = '0; res_fu[k] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            opc[j] = '0; p_reg[j] = '0; o_reg[j] = '0;
        end
    endtask

    // Apply one clock edge to the model with the current inputs, then advance the DUT.
    task automatic tick();
        int sz0;
        int n;
        int idx;
        sz0 = q.size();
        exp_rf[0] = 0;
        exp_rf[1] = 0;
        for (int r = 0; r < RET_W; r++) begin
            if (q.size() == 0) break;
            idx = q[0];
            if (!m_comp[idx]) break;
            void'(q.pop_front());
            m_comp[idx] = 0;
            m_seen = 1;
            if (!m_store[idx]) begin
                exp_rf[r] = 1;
                exp_fp[r] = m_old[idx];
            end
        end
        n = (opc[0] != 0 ? 1 : 0) + (opc[1] != 0 ? 1 : 0);
        if (update_rob && (sz0 + n <= 16)) begin
            for (int j = 0; j < 2; j++) begin
                if (opc[j] != 0) begin
                    m_store[m_tail] = (opc[j] == 7'b0100011);
                    m_old[m_tail]   = o_reg[j];
                    m_comp[m_tail]  = 0;
                    q.push_back(m_tail);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_ff[k] = res_vld[k];
            if (res_vld[k]) begin
                m_comp[res_rob[k]] = 1;
                exp_dr[k] = res_dst[k];
                exp_fd[k] = res_dat[k];
            end
        end
        exp_en = en_ci;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [7:0] any_out;
        clear_inputs();
        en_ci = 1;
        update_rob = 1;
        opc[0] = 7'h33; p_reg[0] = 6'd1; o_reg[0] = 6'd2;
        opc[1] = 7'h33; p_reg[1] = 6'd3; o_reg[1] = 6'd4;
        tick();
        opc[1] = '0;
        res_vld[0] = 1; res_rob[0] = 4'd0; res_dat[0] = 32'hABCD; res_dst[0] = 6'd1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (en_co !== 1'b1 || ff[0] !== 1'b0 || rf[0] !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: en_co=%b ff1=%b rf1=%b required 1 0 1", en_co, ff[0], rf[0]);
        end
        rst = 1;
        #1;
        any_out = {en_co, ff[0], ff[1], ff[2], rf[0], rf[1], pr, 1'b0};
        checks++;
        if (any_out !== 8'd0 || dr[0] !== 6'd0 || fd[0] !== 32'd0 || fp[0] !== 6'd0) begin
            fails++;
            $display("FAIL reset_outputs: flags=%b dr1=%0d fd1=%0h fp1=%0d required all 0", any_out, dr[0], fd[0], fp[0]);
        end
        @(posedge clk);
        #1;
        rst = 0;
        en_ci = 0;
        model_reset();
        tick();
        checks++;
        if (dut.u_rob.count_o !== 5'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d required 0", dut.u_rob.count_o);
        end
    endtask

    task automatic test_forward_retire();
        clear_inputs();
        en_ci = 0;
        update_rob = 1;
        opc[0] = 7'b0110011; p_reg[0] = 6'd40; o_reg[0] = 6'd5;
        opc[1] = 7'b0110011; p_reg[1] = 6'd41; o_reg[1] = 6'd6;
        tick();
        clear_inputs();
        res_vld[0] = 1; res_rob[0] = 4'd1; res_dat[0] = 32'd7; res_dst[0] = 6'd41;
        tick();
        checks++;
        if (ff[0] !== 1'b1 || dr[0] !== 6'd41 || fd[0] !== 32'd7) begin
            fails++;
            $display("FAIL fwd_first: flag=%b dest=%0d data=%0d required 1 41 7", ff[0], dr[0], fd[0]);
        end
        res_rob[0] = 4'd0; res_dat[0] = 32'd3; res_dst[0] = 6'd40;
        tick();
        checks++;
        if (ff[0] !== 1'b1 || dr[0] !== 6'd40 || fd[0] !== 32'd3 || rf[0] !== 1'b0) begin
            fails++;
            $display("FAIL fwd_second: flag=%b dest=%0d data=%0d rf1=%b required 1 40 3 0", ff[0], dr[0], fd[0], rf[0]);
        end
        clear_inputs();
        tick();
        checks++;
        if (ff[0] !== 1'b0 || dr[0] !== 6'd40 || fd[0] !== 32'd3) begin
            fails++;
            $display("FAIL fwd_hold: flag=%b dest=%0d data=%0d required 0 40 3", ff[0], dr[0], fd[0]);
        end
`ifdef COMPLETE_DUAL_RETIRE_EN
        checks++;
        if (rf[0] !== 1'b1 || fp[0] !== 6'd5 || rf[1] !== 1'b1 || fp[1] !== 6'd6) begin
            fails++;
            $display("FAIL dual_retire: rf1=%b fp1=%0d rf2=%b fp2=%0d required 1 5 1 6", rf[0], fp[0], rf[1], fp[1]);
        end
`else
        checks++;
        if (rf[0] !== 1'b1 || fp[0] !== 6'd5 || rf[1] !== 1'b0 || fp[1] !== 6'd0 || pr !== 1'b0) begin
            fails++;
            $display("FAIL single_retire_a: rf1=%b fp1=%0d rf2=%b fp2=%0d pr=%b required 1 5 0 0 0", rf[0], fp[0], rf[1], fp[1], pr);
        end
        tick();
        checks++;
        if (rf[0] !== 1'b1 || fp[0] !== 6'd6 || rf[1] !== 1'b0) begin
            fails++;
            $display("FAIL single_retire_b: rf1=%b fp1=%0d rf2=%b required 1 6 0", rf[0], fp[0], rf[1]);
        end
`endif
        checks++;
        if (pr !== 1'b1) begin
            fails++;
            $display("FAIL drained_pr: got %b required 1", pr);
        end
        en_ci = 1;
        tick();
        checks++;
        if (pr !== 1'b0 || en_co !== 1'b1 || rf[0] !== 1'b0) begin
            fails++;
            $display("FAIL enable_pipe: pr=%b en_co=%b rf1=%b required 0 1 0", pr, en_co, rf[0]);
        end
        en_ci = 0;
    endtask

    task automatic test_store();
        clear_inputs();
        update_rob = 1;
        opc[0] = 7'b0100011; p_reg[0] = 6'd10; o_reg[0] = 6'd20;
        opc[1] = 7'b0110011; p_reg[1] = 6'd11; o_reg[1] = 6'd21;
        tick();
        clear_inputs();
        res_vld[0] = 1; res_rob[0] = 4'd2; res_dat[0] = 32'd100;
        res_vld[1] = 1; res_rob[1] = 4'd3; res_dat[1] = 32'd101;
        tick();
        clear_inputs();
        tick();
`ifdef COMPLETE_DUAL_RETIRE_EN
        checks++;
        if (rf[0] !== 1'b0 || rf[1] !== 1'b1 || fp[1] !== 6'd21) begin
            fails++;
            $display("FAIL store_retire: rf1=%b rf2=%b fp2=%0d required 0 1 21", rf[0], rf[1], fp[1]);
        end
`else
        checks++;
        if (rf[0] !== 1'b0 || dut.u_rob.count_o !== 5'd1) begin
            fails++;
            $display("FAIL store_retire: rf1=%b count=%0d required 0 1", rf[0], dut.u_rob.count_o);
        end
        tick();
        checks++;
        if (rf[0] !== 1'b1 || fp[0] !== 6'd21) begin
            fails++;
            $display("FAIL store_next: rf1=%b fp1=%0d required 1 21", rf[0], fp[0]);
        end
`endif
    endtask

    task automatic test_same_index();
        pulse_reset();
        update_rob = 1;
        opc[0] = 7'h33; p_reg[0] = 6'd1; o_reg[0] = 6'd11;
        opc[1] = 7'h33; p_reg[1] = 6'd2; o_reg[1] = 6'd12;
        tick();
        opc[1] = '0; p_reg[0] = 6'd3; o_reg[0] = 6'd13;
        tick();
        clear_inputs();
        res_vld[0] = 1; res_rob[0] = 4'd2; res_dat[0] = 32'd1; res_dst[0] = 6'd50;
        res_vld[2] = 1; res_rob[2] = 4'd2; res_dat[2] = 32'd9; res_dst[2] = 6'd52;
        tick();
        checks++;
        if (dut.u_rob.rob_q[2].result !== 32'd9 || !dut.u_rob.rob_q[2].comp) begin
            fails++;
            $display("FAIL same_index: result=%0d comp=%b required 9 1", dut.u_rob.rob_q[2].result, dut.u_rob.rob_q[2].comp);
        end
        checks++;
        if (ff[0] !== 1'b1 || fd[0] !== 32'd1 || ff[2] !== 1'b1 || fd[2] !== 32'd9 || ff[1] !== 1'b0) begin
            fails++;
            $display("FAIL same_index_fwd: ff=%b%b%b fd1=%0d fd3=%0d required 101 1 9", ff[0], ff[1], ff[2], fd[0], fd[2]);
        end
        clear_inputs();
        res_vld[0] = 1; res_rob[0] = 4'd0;
        res_vld[1] = 1; res_rob[1] = 4'd1;
        tick();
        clear_inputs();
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        checks++;
        if (pr !== 1'b1 || dut.u_rob.count_o !== 5'd0) begin
            fails++;
            $display("FAIL same_index_drain: pr=%b count=%0d required 1 0", pr, dut.u_rob.count_o);
        end
    endtask

    task automatic test_full_wrap();
        int snap [$];
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            update_rob = 1;
            opc[0] = 7'h33; p_reg[0] = 6'(2 * i + 1); o_reg[0] = 6'(32 + 2 * i);
            opc[1] = 7'h33; p_reg[1] = 6'(2 * i + 2); o_reg[1] = 6'(33 + 2 * i);
            tick();
        end
        checks++;
        if (dut.u_rob.count_o !== 5'd16) begin
            fails++;
            $display("FAIL full_count: got %0d required 16", dut.u_rob.count_o);
        end
        opc[0] = 7'h33; p_reg[0] = 6'd60; o_reg[0] = 6'd61; opc[1] = '0;
        tick();
        checks++;
        if (dut.u_rob.count_o !== 5'd16 || dut.u_rob.rob_q[0].phy_reg !== 6'd1) begin
            fails++;
            $display("FAIL full_drop: count=%0d phy0=%0d required 16 1", dut.u_rob.count_o, dut.u_rob.rob_q[0].phy_reg);
        end
        clear_inputs();
        res_vld[0] = 1; res_rob[0] = 4'd0;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (rf[0] !== 1'b1 || fp[0] !== 6'd32) begin
            fails++;
            $display("FAIL full_retire: rf1=%b fp1=%0d required 1 32", rf[0], fp[0]);
        end
        update_rob = 1;
        opc[0] = 7'h33; p_reg[0] = 6'd60; o_reg[0] = 6'd61;
        tick();
        checks++;
        if (dut.u_rob.rob_q[0].phy_reg !== 6'd60 || !dut.u_rob.rob_q[0].v || dut.u_rob.count_o !== 5'd16) begin
            fails++;
            $display("FAIL wrap_alloc: phy0=%0d v0=%b count=%0d required 60 1 16",
                     dut.u_rob.rob_q[0].phy_reg, dut.u_rob.rob_q[0].v, dut.u_rob.count_o);
        end
        snap = q;
        for (int i = 0; i < snap.size(); i++) begin
            clear_inputs();
            res_vld[0] = 1; res_rob[0] = 4'(snap[i]); res_dat[0] = 32'(i);
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        checks++;
        if (pr !== 1'b1 || dut.u_rob.count_o !== 5'd0) begin
            fails++;
            $display("FAIL wrap_drain: pr=%b count=%0d required 1 0", pr, dut.u_rob.count_o);
        end
    endtask

    task automatic test_random();
        int bad;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            en_ci = ($urandom % 4) == 0;
            update_rob = $urandom % 2;
            pd = 6'($urandom);
            for (int j = 0; j < 2; j++) begin
                case ($urandom % 4)
                    0: opc[j] = 7'd0;
                    1: opc[j] = 7'b0100011;
                    default: opc[j] = 7'b0110011;
                endcase
                p_reg[j] = 6'($urandom);
                o_reg[j] = 6'($urandom);
            end
            for (int k = 0; k < 3; k++) begin
                res_fu[k] = 2'($urandom);
                if (q.size() > 0 && ($urandom % 3) == 0) begin
                    res_vld[k] = 1;
                    res_rob[k] = 4'(q[$urandom % q.size()]);
                    res_dat[k] = $urandom;
                    res_dst[k] = 6'($urandom);
                end
            end
            tick();
            bad = 0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ff[k] !== exp_ff[k] || dr[k] !== exp_dr[k] || fd[k] !== exp_fd[k]) begin
                    fails++; bad = 1;
                    $display("FAIL rand_fwd%0d cyc %0d: %b/%0d/%0h required %b/%0d/%0h",
                             k + 1, c, ff[k], dr[k], fd[k], exp_ff[k], exp_dr[k], exp_fd[k]);
                end
            end
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (rf[j] !== exp_rf[j] || (exp_rf[j] && fp[j] !== exp_fp[j])) begin
                    fails++; bad = 1;
                    $display("FAIL rand_retire%0d cyc %0d: %b/%0d required %b/%0d", j + 1, c, rf[j], fp[j], exp_rf[j], exp_fp[j]);
                end
            end
            checks++;
            if (en_co !== exp_en || pr !== ((q.size() == 0) && m_seen && !en_ci) || dut.u_rob.count_o !== 5'(q.size())) begin
                fails++; bad = 1;
                $display("FAIL rand_state cyc %0d: en_co=%b pr=%b count=%0d required %b %b %0d", c, en_co, pr,
                         dut.u_rob.count_o, exp_en, (q.size() == 0) && m_seen && !en_ci, q.size());
            end
            if (bad != 0 && fails > 20) break;
        end
    endtask

    initial begin
        rst = 1;
        en_ci = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_forward_retire();
        test_store();
        test_same_index();
        test_full_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
